// File: rtl/needs_pkg.sv
// rtl/needs_pkg.sv - shared action codes, FSM states, need limits and deltas
package needs_pkg;

  localparam logic [2:0] ACT_FEED     = 3'd0;
  localparam logic [2:0] ACT_PLAY     = 3'd1;
  localparam logic [2:0] ACT_CLEAN    = 3'd2;
  localparam logic [2:0] ACT_MEDICINE = 3'd3;
  localparam logic [2:0] ACT_PET      = 3'd4;
  localparam logic [2:0] ACT_SLEEP    = 3'd5;

  typedef enum logic [1:0] {
    ST_AWAKE    = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_DEAD     = 2'd2
  } state_t;

  localparam int NEED_MAX = 15;

  localparam logic signed [6:0] FEED_HUNGER_D    = -7'sd4;
  localparam logic signed [6:0] PLAY_HAPPY_D     = -7'sd4;
  localparam logic signed [6:0] PLAY_ENERGY_D    =  7'sd2;
  localparam logic signed [6:0] MED_HEALTH_D     = -7'sd6;
  localparam logic signed [6:0] PET_SOCIAL_D     = -7'sd4;
  localparam logic signed [6:0] PET_HAPPY_D      = -7'sd1;
  localparam logic signed [6:0] SLEEP_ENERGY_D   = -7'sd2;

  // Levels saturate at both ends; the sum is widened so it can never wrap.
  function automatic logic [3:0] apply_delta(input logic [3:0] level,
                                             input logic signed [6:0] delta);
    logic signed [6:0] sum;
    sum = $signed({3'b000, level}) + delta;
    if (sum < 7'sd0)
      return 4'd0;
    else if (sum > $signed(7'(NEED_MAX)))
      return 4'(NEED_MAX);
    else
      return sum[3:0];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - need-tick prescaler with 2-bit phase counter
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Tick is high in the last count cycle, so it lands on the wrap edge.
  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      phase <= 2'd0;
    end else if (enable) begin
      if (tick) begin
        count <= '0;
        phase <= phase + 2'd1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/needs_counters.sv
// rtl/needs_counters.sv - pet need levels driven by periodic ticks and user actions
module needs_counters
  import needs_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       action_valid,
  input  logic [2:0] action_code,
  output logic       action_ready,
  output logic [3:0] hunger,
  output logic [3:0] happiness,
  output logic [3:0] health,
  output logic [3:0] hygiene,
  output logic [3:0] energy,
  output logic [3:0] social,
  output logic       sleeping,
  output logic       dead
);

  state_t state, next_state;
  logic       tick;
  logic [1:0] phase;
  logic       accept;
  logic       clean;
  logic signed [6:0] d_hunger, d_happiness, d_health, d_hygiene, d_energy, d_social;

  assign action_ready = (state == ST_AWAKE);
  assign sleeping     = (state == ST_SLEEPING);
  assign dead         = (state == ST_DEAD);
  assign accept       = action_valid && (state == ST_AWAKE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(state != ST_DEAD),
    .tick  (tick),
    .phase (phase)
  );

  // Tick and action deltas accumulate so both land in one clamped update.
  always_comb begin
    d_hunger    = '0;
    d_happiness = '0;
    d_health    = '0;
    d_hygiene   = '0;
    d_energy    = '0;
    d_social    = '0;
    clean       = 1'b0;
    if (state == ST_AWAKE && tick) begin
      d_hunger = 7'sd1;
      d_energy = 7'sd1;
      if (phase[0]) begin
        d_happiness = 7'sd1;
        d_hygiene   = 7'sd1;
      end
      if (phase == 2'd3)
        d_social = 7'sd1;
      if (hunger >= 4'd12 || hygiene >= 4'd12)
        d_health = 7'sd1;
    end else if (state == ST_SLEEPING && tick) begin
      d_energy = SLEEP_ENERGY_D;
      if (phase[0])
        d_hunger = 7'sd1;
    end
    if (accept) begin
      case (action_code)
        ACT_FEED:     d_hunger = d_hunger + FEED_HUNGER_D;
        ACT_PLAY: begin
          d_happiness = d_happiness + PLAY_HAPPY_D;
          d_energy    = d_energy + PLAY_ENERGY_D;
        end
        ACT_CLEAN:    clean = 1'b1;
        ACT_MEDICINE: d_health = d_health + MED_HEALTH_D;
        ACT_PET: begin
          d_social    = d_social + PET_SOCIAL_D;
          d_happiness = d_happiness + PET_HAPPY_D;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    if (state != ST_DEAD && (hunger == 4'(NEED_MAX) || health == 4'(NEED_MAX)))
      next_state = ST_DEAD;
    else if (state == ST_SLEEPING && energy == 4'd0)
      next_state = ST_AWAKE;
    else if (accept && action_code == ACT_SLEEP)
      next_state = ST_SLEEPING;
  end

  // In DEAD every delta is zero, so the update below holds all levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_AWAKE;
      hunger    <= 4'd0;
      happiness <= 4'd0;
      health    <= 4'd0;
      hygiene   <= 4'd0;
      energy    <= 4'd0;
      social    <= 4'd0;
    end else begin
      state     <= next_state;
      hunger    <= apply_delta(hunger, d_hunger);
      happiness <= apply_delta(happiness, d_happiness);
      health    <= apply_delta(health, d_health);
      hygiene   <= clean ? 4'd0 : apply_delta(hygiene, d_hygiene);
      energy    <= apply_delta(energy, d_energy);
      social    <= apply_delta(social, d_social);
    end
  end

endmodule

// File: tb/tb_needs_counters.sv
// tb/tb_needs_counters.sv - directed self-checking bench for needs_counters
module tb_needs_counters;
  import needs_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       action_valid = 1'b0;
  logic [2:0] action_code = 3'd0;
  logic       action_ready;
  logic [3:0] hunger, happiness, health, hygiene, energy, social;
  logic       sleeping, dead;

  int total = 0;
  int bad = 0;
  int edges = 0;

  needs_counters #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .action_valid(action_valid),
    .action_code (action_code),
    .action_ready(action_ready),
    .hunger      (hunger),
    .happiness   (happiness),
    .health      (health),
    .hygiene     (hygiene),
    .energy      (energy),
    .social      (social),
    .sleeping    (sleeping),
    .dead        (dead)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic check_needs(input string tag, input int h, input int e, input int hp,
                             input int hy, input int s, input int hl);
    check({tag, ".hunger"}, int'(hunger), h);
    check({tag, ".energy"}, int'(energy), e);
    check({tag, ".happiness"}, int'(happiness), hp);
    check({tag, ".hygiene"}, int'(hygiene), hy);
    check({tag, ".social"}, int'(social), s);
    check({tag, ".health"}, int'(health), hl);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic act(input logic [2:0] code);
    action_valid = 1'b1;
    action_code  = code;
    cyc();
    action_valid = 1'b0;
  endtask

  task automatic next_tick();
    cyc();
    while (edges % 4 != 0) cyc();
  endtask

  task automatic tick_act(input logic [2:0] code);
    while (edges % 4 != 3) cyc();
    act(code);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_needs("reset", 0, 0, 0, 0, 0, 0);
    check("reset.sleeping", int'(sleeping), 0);
    check("reset.dead", int'(dead), 0);
    check("reset.ready", int'(action_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    edges = 0;

    idle(3);
    check("first_tick.early", int'(hunger), 0);
    idle(1);
    check("first_tick.hunger", int'(hunger), 1);
    check("first_tick.energy", int'(energy), 1);
    idle(12);
    check_needs("idle16", 4, 4, 2, 2, 1, 0);

    act(ACT_FEED);
    check("feed_clamp", int'(hunger), 0);
    next_tick();
    check("pre_sleep.energy", int'(energy), 5);

    act(ACT_SLEEP);
    check("sleep.sleeping", int'(sleeping), 1);
    check("sleep.ready", int'(action_ready), 0);
    action_valid = 1'b1;
    action_code  = ACT_FEED;
    cyc();
    check("sleep.feed_ignored", int'(hunger), 1);
    next_tick();
    check("sleep.energy3", int'(energy), 3);
    check("sleep.hunger_odd", int'(hunger), 2);
    next_tick();
    check("sleep.energy1", int'(energy), 1);
    check("sleep.hunger_even", int'(hunger), 2);
    next_tick();
    check_needs("sleep.energy0", 3, 0, 2, 2, 1, 0);
    check("sleep.still", int'(sleeping), 1);
    action_valid = 1'b0;
    cyc();
    check("wake.sleeping", int'(sleeping), 0);
    check("wake.ready", int'(action_ready), 1);

    act(ACT_FEED);
    next_tick();
    next_tick();
    check_needs("pre_feed_tick", 2, 2, 3, 3, 1, 0);
    while (edges % 4 != 3) cyc();
    action_valid = 1'b1;
    action_code  = ACT_FEED;
    check("feed_tick.ready", int'(action_ready), 1);
    cyc();
    action_valid = 1'b0;
    check("feed_tick.hunger", int'(hunger), 0);
    check("feed_tick.energy", int'(energy), 3);

    act(ACT_PLAY);
    check("play.happiness", int'(happiness), 0);
    check("play.energy", int'(energy), 5);
    next_tick();
    check_needs("tick_ph3", 1, 6, 1, 4, 2, 0);
    act(ACT_PET);
    check("pet.social", int'(social), 0);
    check("pet.happiness", int'(happiness), 0);
    next_tick();
    tick_act(ACT_CLEAN);
    check_needs("clean_tick", 3, 8, 1, 0, 0, 0);

    while (hunger != 4'd15 && edges < 200) cyc();
    check("starve.edge", edges, 104);
    check_needs("starve", 15, 15, 7, 6, 3, 3);
    check("starve.dead_lag", int'(dead), 0);
    cyc();
    check("dead.dead", int'(dead), 1);
    check("dead.ready", int'(action_ready), 0);
    check("dead.sleeping", int'(sleeping), 0);
    act(ACT_FEED);
    idle(19);
    check_needs("dead_frozen", 15, 15, 7, 6, 3, 3);
    check("dead_frozen.dead", int'(dead), 1);

    #2;
    reset = 1'b1;
    #1;
    check_needs("async_reset", 0, 0, 0, 0, 0, 0);
    check("async_reset.dead", int'(dead), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    edges = 0;

    for (int k = 0; k < 14; k++) next_tick();
    check("hl.k14.hunger", int'(hunger), 14);
    check("hl.k14.health", int'(health), 2);
    tick_act(ACT_FEED);
    for (int r = 0; r < 3; r++) begin
      next_tick();
      next_tick();
      next_tick();
      tick_act(ACT_FEED);
    end
    next_tick();
    next_tick();
    check("hl.k29.hunger", int'(hunger), 13);
    check("hl.k29.health", int'(health), 14);
    check("hl.k29.hygiene", int'(hygiene), 14);
    act(ACT_MEDICINE);
    check("medicine1", int'(health), 8);
    act(ACT_MEDICINE);
    check("medicine2", int'(health), 2);
    next_tick();
    tick_act(ACT_FEED);
    for (int r = 0; r < 2; r++) begin
      next_tick();
      next_tick();
      next_tick();
      tick_act(ACT_FEED);
    end
    next_tick();
    next_tick();
    act(ACT_CLEAN);
    check_needs("hl.pre", 13, 15, 15, 0, 10, 14);
    next_tick();
    check("hl.health15", int'(health), 15);
    check("hl.hunger14", int'(hunger), 14);
    check("hl.dead_lag", int'(dead), 0);
    cyc();
    check("hl.dead", int'(dead), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
